regfile_mp_sb: RTL

// Next-generation parametric register file for the RV32I-MAF core: one writeback port,
// N_RD registered read ports and a per-register pending scoreboard for in-flight results.

---
 rtl/regfile_mp_sb.sv | 105 ++++++++++
 1 files changed

// File: rtl/regfile_mp_sb.sv
// Parametric register file: one writeback port, N_RD registered read ports with
// same-cycle writeback bypass, and a per-register pending scoreboard.
module regfile_mp_sb #(
  parameter int unsigned N_REGS  = 32,
  parameter int unsigned R_WIDTH = 32,
  parameter int unsigned N_RD    = 2,
  parameter int unsigned ZERO_R0 = 1,
  localparam int unsigned W_ADDR = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wb_en,
  input  logic [W_ADDR-1:0]         wb_addr,
  input  logic [R_WIDTH-1:0]        wb_data,
  input  logic                      rsv_en,
  input  logic [W_ADDR-1:0]         rsv_addr,
  input  logic [N_RD-1:0]           rd_en,
  input  logic [N_RD-1:0]           rd_fwd,
  input  logic [N_RD*W_ADDR-1:0]    rd_addr,
  output logic [N_RD*R_WIDTH-1:0]   rd_data,
  output logic [N_RD-1:0]           rd_busy,
  output logic [N_REGS-1:0]         pending
);

  logic [R_WIDTH-1:0] regs_q [N_REGS];
  logic [N_REGS-1:0]  pending_q, pending_d;
  logic               wr_ok, rsv_ok;

  // Addresses beyond N_REGS exist only when N_REGS is not a power of two.
  function automatic logic addr_ok(input logic [W_ADDR-1:0] a);
    return 32'(a) < N_REGS;
  endfunction

  function automatic logic is_zero_reg(input logic [W_ADDR-1:0] a);
    return (ZERO_R0 != 0) && (a == '0);
  endfunction

  assign wr_ok  = wb_en && addr_ok(wb_addr) && !is_zero_reg(wb_addr);
  assign rsv_ok = rsv_en && addr_ok(rsv_addr) && !is_zero_reg(rsv_addr);

  // Register storage: single writeback port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < int'(N_REGS); r++) regs_q[r] <= '0;
    end else if (wr_ok) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  // Scoreboard next state: a reservation overrides a same-cycle writeback clear.
  always_comb begin
    pending_d = pending_q;
    if (wr_ok)  pending_d[wb_addr]  = 1'b0;
    if (rsv_ok) pending_d[rsv_addr] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign pending = pending_q;

  for (genvar p = 0; p < int'(N_RD); p++) begin : g_rd
    logic [W_ADDR-1:0]  addr;
    logic [R_WIDTH-1:0] data_d, data_q;
    logic               busy_d, busy_q;

    assign addr = rd_addr[p*W_ADDR +: W_ADDR];

    // Read source select; busy reflects the scoreboard before this edge's update.
    always_comb begin
      data_d = data_q;
      busy_d = busy_q;
      if (rd_en[p]) begin
        if (!addr_ok(addr) || is_zero_reg(addr)) begin
          data_d = '0;
          busy_d = 1'b0;
        end else if (rd_fwd[p] && wb_en && (wb_addr == addr)) begin
          data_d = wb_data;
          busy_d = 1'b0;
        end else begin
          data_d = regs_q[addr];
          busy_d = pending_q[addr];
        end
      end
    end

    // Read port output registers; hold when the port is idle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q <= '0;
        busy_q <= 1'b0;
      end else begin
        data_q <= data_d;
        busy_q <= busy_d;
      end
    end

    assign rd_data[p*R_WIDTH +: R_WIDTH] = data_q;
    assign rd_busy[p]                    = busy_q;
  end

endmodule
